vdc_hsync_meter: RTL
====================

Name: vdc_hsync_meter

Overview:
- Receive-side measurement block for the VDC horizontal timing signals (hsync, hdispen), running on the same pixel-enable domain.
- Recovers per-line timing in pixel ticks: line total, sync width, display-enable start and width.
- Declares lock once a configurable number of consecutive lines match.
- Used by the video output/scaler path and by self-check logic that validates register-programmed timing (R0/R1/R3/R22/R34/R35).

Parameters:
- CW, 12, width of all pixel counters and measured outputs.
- MIN_LINE, 64, a line shorter than this (in ticks) is a glitch and is ignored.
- LOCK_LINES, 4, consecutive identical measured lines required to assert locked.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  pixel clock enable; all counting and sampling occur only when high
- hsync  input  1  horizontal sync, active high
- hdispen  input  1  horizontal display enable, active high
- newLine  output  1  one-enable-cycle pulse on the tick an accepted hsync rising edge is seen
- xpos  output  CW  ticks since last accepted hsync rise (0 on the newLine tick)
- line_total  output  CW  last accepted line length in ticks
- sync_width  output  CW  hsync high duration of the last completed sync pulse
- de_start  output  CW  xpos at first hdispen rise in the last completed line
- de_width  output  CW  total hdispen-high ticks in the last completed line
- locked  output  1  timing stable
- timeout  output  1  sticky until the next accepted line; set when xpos saturates

Behaviour:
- Reset (async, reset_n low) clears all outputs, state and internal counters to 0, with state=SEARCH. Reset mid-line discards the partial measurement.
- hsync and hdispen are sampled on enable ticks only. Edges are detected against the previous sampled value (prev regs reset to 0).
- States:
  - SEARCH: wait for an hsync rise; then clear counters and go to MEASURE. Nothing is latched.
  - MEASURE: accumulate. On an accepted hsync rise, latch results and go to LOCKED once the match count reaches LOCK_LINES; otherwise stay.
  - LOCKED: same as MEASURE. A mismatching line drops to MEASURE.
- Accepted rise: hsync rise with xpos+1 >= MIN_LINE. On it:
  - line_total <= xpos+1; xpos <= 0; newLine=1 (newLine is registered, high for exactly one enable tick).
  - de_start/de_width latch the current-line accumulators, which then clear.
  - A rise with xpos+1 < MIN_LINE is ignored: no counter reset, no latch, no newLine.
- xpos increments each enable tick and saturates at 2^CW-1. On saturation: timeout=1, locked=0, match count=0, state=SEARCH.
- sync_width: an internal counter clears on an hsync rise (accepted or not) and increments while sampled hsync is high. It is latched on the hsync fall.
  - The hsync-rise tick counts as 1; a 1-tick pulse gives 1.
- de_start: captured at the first hdispen rise of the line.
  - If hdispen is already high on the newLine tick, de_start=0.
  - If hdispen never rises in the line, the latched de_start=0 and de_width=0.
- de_width: counts every enable tick with hdispen high within the line.
  - Multiple DE pulses in one line sum.
  - hdispen high across the line boundary: the high tick on the newLine tick counts for the new line.
- Match rule: the new line_total equals the previous line_total.
  - Match count saturates at LOCK_LINES; locked=1 when it is reached.
  - A mismatch resets the count to 1 (the current line is the new reference) and clears locked the same tick.
- Simultaneous hsync rise and hdispen rise on one tick: the rise belongs to the new line, so de_start=0.
- enable low: every register holds, including pulses (newLine is cleared on the next enable tick).

Decomposition:
- Package vdc_pkg: state enum (SEARCH, MEASURE, LOCKED) and the default CW constant.
- One natural sub-module, vdc_edge_counter: sampled input, prev reg, rise/fall strobes, a saturating high-time counter with clear. Instantiate it for hsync and for hdispen.

Test Plan:
- VDC defaults (R0=127, R22 cth=7 → 8 px/char, R3 hw=9, hdispen cols 6..85) driven from a model, continuous enable → after 4 lines: line_total=1024, sync_width=72, de_start=48, de_width=640, locked=1.
- 20-tick hsync glitch at xpos=30 inside a 1024-tick line → no newLine, line_total stays 1024, locked stays 1.
- Line total switched 1024→1032 for one line, then back → locked drops on the 1032 line. Re-lock is required on the 4th consecutive 1024 line after the 1032 one.
- hsync held low for 4096 ticks with CW=12 → timeout=1, locked=0, state SEARCH. The next two rises 1024 apart give line_total=1024 and timeout=0.
- enable toggling 1-of-2 with the same per-tick waveform → identical measured values to the continuous case. newLine is high across the disabled gap until the next enable tick.
- reset_n asserted mid-line while LOCKED → all outputs 0 immediately (async). After release, the first hsync rise produces no latch.

Source files
------------

// File: rtl/vdc_pkg.sv
`default_nettype none
// ============================================================================
// Package : vdc_pkg
// Brief   : Shared types and defaults for the VDC horizontal timing meter.
// Rev     : 1.0  initial release
// ============================================================================
package vdc_pkg;

  // Default width of the pixel counters and measured results.
  localparam int CW_DEFAULT = 12;

  // Measurement state: hunting for a line start, measuring, or stable.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage : vdc_pkg
`default_nettype wire

// File: rtl/vdc_hsync_meter_if.sv
`default_nettype none
// ============================================================================
// Interface : vdc_hsync_meter_if
// Brief     : Horizontal timing inputs and measured results of the meter.
//             The timing source is the master, the meter is the slave.
// Rev       : 1.0  initial release
// ============================================================================
interface vdc_hsync_meter_if
  import vdc_pkg::*;
#(
  parameter int CW = CW_DEFAULT
);
  logic          enable;
  logic          hsync;
  logic          hdispen;
  logic          newLine;
  logic [CW-1:0] xpos;
  logic [CW-1:0] line_total;
  logic [CW-1:0] sync_width;
  logic [CW-1:0] de_start;
  logic [CW-1:0] de_width;
  logic          locked;
  logic          timeout;

  modport master (
    output enable, hsync, hdispen,
    input  newLine, xpos, line_total, sync_width, de_start, de_width, locked, timeout
  );

  modport slave (
    input  enable, hsync, hdispen,
    output newLine, xpos, line_total, sync_width, de_start, de_width, locked, timeout
  );
endinterface : vdc_hsync_meter_if
`default_nettype wire

// File: rtl/vdc_edge_counter.sv
`default_nettype none
// ============================================================================
// Module : vdc_edge_counter
// Brief  : Samples one timing input on enable ticks, flags its rise/fall
//          against the previous sample and counts high ticks (saturating).
//          A clear restarts the count, counting the clear tick if high.
// Rev    : 1.0  initial release
// ============================================================================
module vdc_edge_counter
  import vdc_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          din,
  input  logic          clr,
  output logic          rise,
  output logic          fall,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] c_one = CW'(1);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q,  cnt_d;

  assign rise = en & din & ~prev_q;
  assign fall = en & ~din & prev_q;
  assign cnt  = cnt_q;

  // Next-state: remember the sample and update the high-time counter.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (en) begin
      prev_d = din;
      if (clr) begin
        cnt_d = din ? c_one : '0;
      end else if (din && (cnt_q != '1)) begin
        cnt_d = cnt_q + c_one;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : vdc_edge_counter
`default_nettype wire

// File: rtl/vdc_hsync_meter.sv
`default_nettype none
// ============================================================================
// Module : vdc_hsync_meter
// Brief  : Measures per-line horizontal timing (line total, sync width,
//          display-enable start/width) in pixel ticks and declares lock
//          after LOCK_LINES consecutive equal line totals.
// Rev    : 1.0  initial release
// ============================================================================
module vdc_hsync_meter
  import vdc_pkg::*;
#(
  parameter int CW         = CW_DEFAULT,
  parameter int MIN_LINE   = 64,
  parameter int LOCK_LINES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  vdc_hsync_meter_if.slave bus
);
  localparam int            c_mw      = $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0] c_one     = CW'(1);
  localparam logic [CW:0]   c_len_one = (CW+1)'(1);
  localparam logic [CW:0]   c_min_len = (CW+1)'(MIN_LINE);
  localparam logic [CW:0]   c_sat_len = {1'b0, {CW{1'b1}}};
  localparam logic [c_mw-1:0] c_m_one  = c_mw'(1);
  localparam logic [c_mw-1:0] c_m_lock = c_mw'(LOCK_LINES);

  state_e          state_q, state_d;
  logic [CW-1:0]   xpos_q, xpos_d;
  logic [CW-1:0]   line_total_q, line_total_d;
  logic [CW-1:0]   sync_width_q, sync_width_d;
  logic [CW-1:0]   de_start_q, de_start_d;
  logic [CW-1:0]   de_width_q, de_width_d;
  logic [CW-1:0]   de_first_q, de_first_d;
  logic            de_seen_q, de_seen_d;
  logic [c_mw-1:0] match_q, match_d;
  logic            locked_q, locked_d;
  logic            timeout_q, timeout_d;
  logic            new_line_q, new_line_d;

  logic            w_hs_rise, w_hs_fall, w_de_rise, w_de_fall_unused;
  logic [CW-1:0]   w_hs_cnt, w_de_cnt;
  logic [CW:0]     w_len;
  logic            w_accept, w_search_start, w_line_start, w_sat_hit;

  // hsync: count restarts on every rise, accepted or not.
  vdc_edge_counter #(.CW(CW)) u_hs (
    .clk(clk), .reset_n(reset_n), .en(bus.enable), .din(bus.hsync),
    .clr(w_hs_rise), .rise(w_hs_rise), .fall(w_hs_fall), .cnt(w_hs_cnt)
  );

  // hdispen: accumulates across all DE pulses until the next line start.
  vdc_edge_counter #(.CW(CW)) u_de (
    .clk(clk), .reset_n(reset_n), .en(bus.enable), .din(bus.hdispen),
    .clr(w_line_start), .rise(w_de_rise), .fall(w_de_fall_unused), .cnt(w_de_cnt)
  );

  // Length the current line would have if it ended on this tick.
  assign w_len          = {1'b0, xpos_q} + c_len_one;
  assign w_accept       = w_hs_rise && (state_q != SEARCH) && (w_len >= c_min_len);
  assign w_search_start = w_hs_rise && (state_q == SEARCH);
  assign w_line_start   = w_accept || w_search_start;
  assign w_sat_hit      = bus.enable && !w_line_start && (w_len == c_sat_len);

  // Next-state: position counter, DE start capture, line latch and lock FSM.
  always_comb begin
    state_d      = state_q;
    xpos_d       = xpos_q;
    line_total_d = line_total_q;
    sync_width_d = sync_width_q;
    de_start_d   = de_start_q;
    de_width_d   = de_width_q;
    de_first_d   = de_first_q;
    de_seen_d    = de_seen_q;
    match_d      = match_q;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    new_line_d   = new_line_q;
    if (bus.enable) begin
      new_line_d = 1'b0;
      if (w_line_start) begin
        xpos_d = '0;
      end else if (xpos_q != '1) begin
        xpos_d = xpos_q + c_one;
      end
      if (w_hs_fall) begin
        sync_width_d = w_hs_cnt;
      end
      // DE already high on the line-start tick means it starts at xpos 0.
      if (w_line_start) begin
        de_seen_d  = bus.hdispen;
        de_first_d = '0;
      end else if (w_de_rise && !de_seen_q) begin
        de_seen_d  = 1'b1;
        de_first_d = xpos_d;
      end
      if (w_accept) begin
        new_line_d   = 1'b1;
        line_total_d = w_len[CW-1:0];
        de_start_d   = de_first_q;
        de_width_d   = w_de_cnt;
        timeout_d    = 1'b0;
        if (w_len[CW-1:0] == line_total_q) begin
          if (match_q != c_m_lock) begin
            match_d = match_q + c_m_one;
          end
        end else begin
          match_d = c_m_one;
        end
        locked_d = (match_d == c_m_lock);
        state_d  = locked_d ? LOCKED : MEASURE;
      end else if (w_search_start) begin
        state_d = MEASURE;
      end else if (w_sat_hit) begin
        timeout_d = 1'b1;
        locked_d  = 1'b0;
        match_d   = '0;
        state_d   = SEARCH;
      end
    end
  end

  // State registers; reset discards any partial measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      xpos_q       <= '0;
      line_total_q <= '0;
      sync_width_q <= '0;
      de_start_q   <= '0;
      de_width_q   <= '0;
      de_first_q   <= '0;
      de_seen_q    <= 1'b0;
      match_q      <= '0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      new_line_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      xpos_q       <= xpos_d;
      line_total_q <= line_total_d;
      sync_width_q <= sync_width_d;
      de_start_q   <= de_start_d;
      de_width_q   <= de_width_d;
      de_first_q   <= de_first_d;
      de_seen_q    <= de_seen_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      new_line_q   <= new_line_d;
    end
  end

  assign bus.newLine    = new_line_q;
  assign bus.xpos       = xpos_q;
  assign bus.line_total = line_total_q;
  assign bus.sync_width = sync_width_q;
  assign bus.de_start   = de_start_q;
  assign bus.de_width   = de_width_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;

endmodule : vdc_hsync_meter
`default_nettype wire
